temp_servo_sequencer: RTL
=========================

TEMP_SERVO_SEQUENCER -- requirements
Module: temp_servo_sequencer

Interface
REQ-001 Parameters SHALL be: FILTER_IO_SIZE, 18, PID I/O word width; multBits, 7, errmult width; CNTW, 16, counter width; RAMP_DIV, 1000, clk cycles per errmult ramp step.
REQ-002 Ports SHALL be (clock and reset first):
- clk  in  1  125 kHz PID clock;
- rst_n  in  1  reset;
- enable  in  1  servo enable request;
- clear_fault  in  1  fault acknowledge;
- s_in  in  FILTER_IO_SIZE signed  error signal fed to the PID;
- NH  in  FILTER_IO_SIZE signed  PID output readback;
- UL, LL  in  FILTER_IO_SIZE signed  PID output limits;
- errmult_tgt  in  multBits signed  final gain multiplier (16 = unity);
- lock_win  in  FILTER_IO_SIZE unsigned  lock window on |s_in|;
- lock_cnt  in  CNTW  consecutive in-window cycles required for lock;
- fault_cnt  in  CNTW  consecutive saturated cycles required to trip;
- pid_on  out  1  PID on;
- errmult  out  multBits signed  gain multiplier to the PID;
- locked  out  1  lock flag;
- fault  out  1  fault flag;
- state  out  3  FSM state code.
REQ-003 Reset SHALL be synchronous and active-low on rst_n, sampled on the rising edge of clk; clk is the only clock.

Function
REQ-004 The FSM SHALL have the states IDLE=0, RAMP=1, TRACK=2, LOCKED=3 and FAULT=4; all outputs SHALL be registered.
REQ-005 In IDLE: pid_on=0, errmult=4, locked=0; enable=1 with fault=0 SHALL give RAMP on the next edge, with pid_on=1 and errmult=4 in that same cycle.
REQ-006 In RAMP, errmult SHALL increment by 1 once every RAMP_DIV cycles until it equals errmult_tgt.
REQ-007 In RAMP, if errmult_tgt is at or below the current errmult, errmult SHALL load errmult_tgt on the next edge and the FSM SHALL enter TRACK.
REQ-008 In RAMP, reaching errmult_tgt SHALL cause TRACK on the next edge; the ramp divider SHALL reset to 0 on entry to RAMP.
REQ-009 In TRACK and LOCKED, errmult SHALL follow errmult_tgt with 1 cycle of latency.
REQ-010 |s_in| SHALL be computed so that the most-negative s_in saturates to 2^(FILTER_IO_SIZE-1)-1.
REQ-011 In TRACK, the lock counter SHALL increment when |s_in| <= lock_win and SHALL clear to 0 otherwise.
REQ-012 In TRACK, when the lock counter reaches lock_cnt, the FSM SHALL enter LOCKED with locked=1; lock_cnt=0 or 1 SHALL lock after 1 in-window cycle.
REQ-013 In LOCKED, |s_in| > lock_win SHALL cause TRACK on the next edge, with locked=0 and the lock counter cleared.
REQ-014 enable=0 in RAMP, TRACK or LOCKED SHALL cause IDLE on the next edge, clearing all counters.
REQ-015 Fault detection SHALL take priority over enable=0 when both occur in the same cycle.
REQ-016 All counters SHALL saturate at 2^CNTW-1 and never wrap.

Reset
REQ-017 On rst_n=0, the sequencer SHALL enter IDLE with pid_on=0, errmult=4, locked=0, fault=0, state=0 and all counters 0; this SHALL hold mid-ramp or mid-fault.

Configuration
REQ-018 With macro TEMPSEQ_FAULT_EN defined, a saturation counter SHALL increment in RAMP, TRACK and LOCKED while NH>=UL or NH<=LL, and SHALL clear otherwise.
REQ-019 With TEMPSEQ_FAULT_EN defined, the saturation counter reaching fault_cnt (nonzero) SHALL cause FAULT on the next edge, with pid_on=0, errmult=0, locked=0 and fault=1.
REQ-020 With TEMPSEQ_FAULT_EN defined, FAULT SHALL exit to IDLE only on a cycle with clear_fault=1 and enable=0; fault SHALL then clear.
REQ-021 With TEMPSEQ_FAULT_EN defined, fault_cnt=0 SHALL disable tripping.
REQ-022 Without TEMPSEQ_FAULT_EN, the fault output SHALL be constant 0, FAULT SHALL be unreachable and the saturation counter SHALL be absent.

Verification
REQ-023 Ramp: RAMP_DIV=4, errmult_tgt=16, enable rises at cycle 0 -> state=1 and errmult=4 at cycle 1; errmult=16 after 48 further cycles; state=2 next cycle.
REQ-024 Down-target: errmult_tgt=2 while in RAMP -> errmult=2 and state=2 on the next edge.
REQ-025 Lock: lock_win=100, lock_cnt=5, s_in=-50 held -> locked=1 after 5 TRACK cycles; s_in=-2^17 for one cycle -> state=2 and locked=0 on the next edge.
REQ-026 Fault (macro on): fault_cnt=10, NH=UL held in LOCKED -> fault=1, pid_on=0 and state=4 after 10 cycles; clear_fault=1 with enable=1 -> stays in FAULT; with enable=0 -> IDLE.
REQ-027 Reset mid-ramp: rst_n=0 for 1 cycle at errmult=9 -> state=0, errmult=4, pid_on=0 on the next edge; simultaneous enable=0 and fault trip -> state=4.

Source files
------------

// File: rtl/temp_servo_sequencer.sv
// Start-up sequencer for a temperature-servo PID: gain ramp, lock detection and optional saturation fault.
// Define TEMPSEQ_FAULT_EN to build the saturation counter and the FAULT state.
module temp_servo_sequencer #(
  parameter int FILTER_IO_SIZE = 18,
  parameter int multBits       = 7,
  parameter int CNTW           = 16,
  parameter int RAMP_DIV       = 1000
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              enable,
  input  logic                              clear_fault,
  input  logic signed [FILTER_IO_SIZE-1:0]  s_in,
  input  logic signed [FILTER_IO_SIZE-1:0]  NH,
  input  logic signed [FILTER_IO_SIZE-1:0]  UL,
  input  logic signed [FILTER_IO_SIZE-1:0]  LL,
  input  logic signed [multBits-1:0]        errmult_tgt,
  input  logic        [FILTER_IO_SIZE-1:0]  lock_win,
  input  logic        [CNTW-1:0]            lock_cnt,
  input  logic        [CNTW-1:0]            fault_cnt,
  output logic                              pid_on,
  output logic signed [multBits-1:0]        errmult,
  output logic                              locked,
  output logic                              fault,
  output logic        [2:0]                 state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RAMP   = 3'd1,
    S_TRACK  = 3'd2,
    S_LOCKED = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  localparam logic        [CNTW-1:0]           CNT_MAX  = '1;
  localparam logic        [CNTW-1:0]           DIV_LAST = CNTW'(RAMP_DIV - 1);
  localparam logic signed [multBits-1:0]       EM_INIT  = multBits'(4);
  localparam logic        [FILTER_IO_SIZE-1:0] ABS_MAX  = {1'b0, {(FILTER_IO_SIZE-1){1'b1}}};
  localparam logic signed [FILTER_IO_SIZE-1:0] S_MIN    = {1'b1, {(FILTER_IO_SIZE-1){1'b0}}};

  state_t                       r_state;
  logic                         r_pid_on;
  logic signed [multBits-1:0]   r_errmult;
  logic                         r_locked;
  logic        [CNTW-1:0]       r_div_cnt;
  logic        [CNTW-1:0]       r_lock_cnt;

  logic        [FILTER_IO_SIZE-1:0] w_s_abs;
  logic                             w_in_win;
  logic        [CNTW-1:0]           w_lock_next;
  logic                             w_lock_hit;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_s_abs = s_in;
    if (s_in == S_MIN)
      w_s_abs = ABS_MAX;
    else if (s_in[FILTER_IO_SIZE-1])
      w_s_abs = -s_in;
  end

  assign w_in_win    = (w_s_abs <= lock_win);
  assign w_lock_next = !w_in_win ? '0 :
                       (r_lock_cnt == CNT_MAX) ? CNT_MAX : r_lock_cnt + 1'b1;
  // lock_cnt of 0 behaves like 1: the first in-window cycle already satisfies it.
  assign w_lock_hit  = w_in_win && (w_lock_next >= lock_cnt);

`ifdef TEMPSEQ_FAULT_EN
  logic            r_fault;
  logic [CNTW-1:0] r_sat_cnt;
  logic            w_sat;
  logic [CNTW-1:0] w_sat_next;
  logic            w_active;
  logic            w_trip;

  assign w_active   = (r_state == S_RAMP) || (r_state == S_TRACK) || (r_state == S_LOCKED);
  assign w_sat      = (NH >= UL) || (NH <= LL);
  assign w_sat_next = !w_sat ? '0 :
                      (r_sat_cnt == CNT_MAX) ? CNT_MAX : r_sat_cnt + 1'b1;
  assign w_trip     = w_active && (fault_cnt != '0) && (w_sat_next >= fault_cnt);

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_sat_cnt <= '0;
    else if (w_active && enable && !w_trip)
      r_sat_cnt <= w_sat_next;
    else
      r_sat_cnt <= '0;
  end

  assign fault = r_fault;
`else
  logic w_unused;
  assign w_unused = ^{clear_fault, NH, UL, LL, fault_cnt};
  assign fault    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pid_on   <= 1'b0;
      r_errmult  <= EM_INIT;
      r_locked   <= 1'b0;
      r_div_cnt  <= '0;
      r_lock_cnt <= '0;
`ifdef TEMPSEQ_FAULT_EN
      r_fault    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_state   <= S_RAMP;
            r_pid_on  <= 1'b1;
            r_errmult <= EM_INIT;
            r_div_cnt <= '0;
          end
        end

        S_RAMP, S_TRACK, S_LOCKED: begin
          // A saturation trip outranks a simultaneous enable drop.
`ifdef TEMPSEQ_FAULT_EN
          if (w_trip) begin
            r_state    <= S_FAULT;
            r_pid_on   <= 1'b0;
            r_errmult  <= '0;
            r_locked   <= 1'b0;
            r_fault    <= 1'b1;
            r_div_cnt  <= '0;
            r_lock_cnt <= '0;
          end else
`endif
          if (!enable) begin
            r_state    <= S_IDLE;
            r_pid_on   <= 1'b0;
            r_errmult  <= EM_INIT;
            r_locked   <= 1'b0;
            r_div_cnt  <= '0;
            r_lock_cnt <= '0;
          end else if (r_state == S_RAMP) begin
            r_lock_cnt <= '0;
            if (errmult_tgt <= r_errmult) begin
              r_errmult <= errmult_tgt;
              r_state   <= S_TRACK;
              r_div_cnt <= '0;
            end else if (r_div_cnt >= DIV_LAST) begin
              r_errmult <= r_errmult + multBits'(1);
              r_div_cnt <= '0;
            end else begin
              r_div_cnt <= r_div_cnt + 1'b1;
            end
          end else begin
            r_errmult <= errmult_tgt;
            if (r_state == S_TRACK) begin
              r_lock_cnt <= w_lock_next;
              if (w_lock_hit) begin
                r_state  <= S_LOCKED;
                r_locked <= 1'b1;
              end
            end else if (!w_in_win) begin
              r_state    <= S_TRACK;
              r_locked   <= 1'b0;
              r_lock_cnt <= '0;
            end
          end
        end

`ifdef TEMPSEQ_FAULT_EN
        S_FAULT: begin
          if (clear_fault && !enable) begin
            r_state   <= S_IDLE;
            r_fault   <= 1'b0;
            r_errmult <= EM_INIT;
          end
        end
`endif

        default: begin
          r_state    <= S_IDLE;
          r_pid_on   <= 1'b0;
          r_errmult  <= EM_INIT;
          r_locked   <= 1'b0;
          r_div_cnt  <= '0;
          r_lock_cnt <= '0;
        end
      endcase
    end
  end

  assign pid_on  = r_pid_on;
  assign errmult = r_errmult;
  assign locked  = r_locked;
  assign state   = r_state;

endmodule
